riscv_mc_controller: RTL and testbench
======================================

# riscv_mc_controller

Multi-cycle control FSM for the RV32I subset datapath. It drives the existing 32-bit ALU's 2-bit ALUControl (00 add, 01 sub, 10 and, 11 or) and consumes its Zero flag. It also sequences PC, instruction-register, memory and register-file enables across one shared memory and one ALU. It sits between the instruction register and the datapath muxes.

## Interface

- No parameters; all widths fixed.
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- op  input  7  instr[6:0].
- funct3  input  3  instr[14:12].
- funct7b5  input  1  instr[30].
- Zero  input  1  ALU zero flag.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address mux: 0 PC, 1 ALUOut.
- MemWrite  output  1  data memory write enable.
- IRWrite  output  1  instruction/OldPC register enable.
- RegWrite  output  1  register file write enable.
- ResultSrc  output  2  result mux: 00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 rs1 data.
- ALUSrcB  output  2  00 rs2 data, 01 ImmExt, 10 constant 4.
- ImmSrc  output  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- ALUControl  output  2  ALU operation.
- IllegalOp  output  1  one-cycle pulse on an unsupported instruction.
- State  output  4  current state, for debug.

## Operation

- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10. Codes 11–15 are unused and go to FETCH on the next edge, with all outputs at 0.
- Transitions:
  - FETCH→DECODE.
  - DECODE: lw(0000011)/sw(0100011)→MEMADR; R(0110011)→EXECUTER; I-ALU(0010011)→EXECUTEI; jal(1101111)→JAL; beq(1100011)→BEQ; any other op→FETCH.
  - MEMADR: op[5]=0→MEMREAD, op[5]=1→MEMWRITE.
  - MEMREAD→MEMWB.
  - EXECUTER, EXECUTEI, JAL→ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ→FETCH.
- Moore outputs per state. Unlisted outputs are 0; ALUOp is internal.
  - FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precompute).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- PCWrite = PCUpdate | (Branch & Zero). This is combinational from the state and Zero.
- ALU decoder (combinational):
  - ALUOp 00→00 (add); ALUOp 01→01 (sub).
  - ALUOp 10, by funct3:
    - 000: 01 if op[5]&funct7b5, else 00.
    - 110: 11.
    - 111: 10.
    - other funct3: 00, with IllegalOp=1 during that execute state.
- ImmSrc is decoded combinationally from op in every state: lw/I-ALU 00, sw 01, beq 10, jal 11, other 00.
- IllegalOp=1 in DECODE when op is unsupported, and in EXECUTER/EXECUTEI when funct3 is unsupported. An unsupported-funct3 instruction still completes its ALUWB.

## Timing

- The state register updates on the CLK rising edge. RST asynchronously forces FETCH.
- Reset output values: state FETCH, so State=0, IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10, all others 0.
  - The datapath must hold its PC/IR under its own reset, so FETCH enables during reset are harmless.
- Reset asserted mid-instruction aborts immediately. No MemWrite or RegWrite is issued after RST rises. The first edge after deassert leaves FETCH.
- Cycles per instruction: lw 5, sw 4, R 4, I-ALU 4, jal 4, beq 3, unsupported op 2.
- The Zero path to PCWrite is combinational within the BEQ cycle, with no registering. The ALU result used is (rs1 − rs2) in that same cycle.
- IR/op are stable from DECODE until the return to FETCH, because IRWrite is asserted only in FETCH.

## Test plan

- Reset: assert RST mid-MEMWRITE → State=0 and MemWrite=0 asynchronously, before the next edge. Deassert → state sequence 0→1.
- lw (op=0000011): states 0,1,2,3,4,0. MEMWB has RegWrite=1 and ResultSrc=01. ALUControl=00 in MEMADR. ImmSrc=00 throughout.
- R-type sub (op=0110011, funct3=000, funct7b5=1): EXECUTER gives ALUControl=01. R-type or (funct3=110) gives 11. I-type addi with funct7b5=1 (op[5]=0) gives 00.
- beq (op=1100011): in BEQ, Zero=1 → PCWrite=1; Zero=0 → PCWrite=0. ALUControl=01, ImmSrc=10. Next state is FETCH.
- jal (op=1101111): states 0,1,9,7,0. JAL has PCWrite=1, ALUSrcA=01, ALUSrcB=10. ALUWB has RegWrite=1.
- Illegal: op=1110011 → IllegalOp=1 in DECODE, then FETCH with no RegWrite/MemWrite. R-type funct3=100 → IllegalOp=1 in EXECUTER and ALUControl=00.

Source files
------------

// File: rtl/riscv_mc_controller_if.sv
// riscv_mc_controller_if
// Control bus between the multi-cycle RV32I datapath and its controller.
//   op, funct3, funct7b5 : instruction fields taken from the instruction register
//   Zero                 : ALU zero flag
//   PCWrite .. ALUControl: datapath enables and mux selects
//   IllegalOp            : one-cycle pulse on an unsupported instruction
//   State                : controller state code, for debug
// This bus has no valid/ready handshake. Every signal is a level that is
// meaningful in each clock cycle. The controller decodes its outputs from its
// state register and from the current inputs.
interface riscv_mc_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [1:0] ALUControl;
  logic       IllegalOp;
  logic [3:0] State;

  // The datapath (or the bench) side drives the instruction fields and Zero.
  modport master (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalOp, State
  );

  // The controller side drives the enables and selects.
  modport slave (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalOp, State
  );
endinterface

// File: rtl/riscv_mc_controller.sv
// riscv_mc_controller
// Multi-cycle control FSM for the RV32I subset (lw, sw, R-type, I-ALU, jal, beq).
// It shares one memory and one ALU across the cycles of each instruction.
//   CLK : system clock, rising edge
//   RST : asynchronous active-high reset that forces FETCH
//   bus : slave side of riscv_mc_controller_if (instruction fields and Zero
//         come in; enables, selects, IllegalOp and the State debug code go out)
// The Moore outputs are decoded from the state register. PCWrite, ImmSrc,
// ALUControl and IllegalOp also depend on the current inputs.
module riscv_mc_controller (
  input logic                  CLK,
  input logic                  RST,
  riscv_mc_controller_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t state;

  // State register. Codes 11-15 cannot be reached normally. They fall back to FETCH.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    state <= DECODE;
        DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_R:         state <= EXECUTER;
            OP_I:         state <= EXECUTEI;
            OP_JAL:       state <= JAL;
            OP_BEQ:       state <= BEQ;
            default:      state <= FETCH;
          endcase
        end
        MEMADR:   state <= bus.op[5] ? MEMWRITE : MEMREAD;
        MEMREAD:  state <= MEMWB;
        EXECUTER: state <= ALUWB;
        EXECUTEI: state <= ALUWB;
        JAL:      state <= ALUWB;
        default:  state <= FETCH;  // MEMWB, MEMWRITE, ALUWB, BEQ, unused codes
      endcase
    end
  end

  logic       pc_update;
  logic       branch;
  logic [1:0] alu_op;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic       state_valid;

  // Moore decode of the state register.
  always_comb begin
    pc_update   = 1'b0;
    branch      = 1'b0;
    alu_op      = 2'b00;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    state_valid = 1'b1;
    case (state)
      FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
      end
      DECODE: begin
        // OldPC + ImmExt gives the branch target, which is ready before BEQ.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD:  adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      ALUWB:    reg_write = 1'b1;
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      default:  state_valid = 1'b0;
    endcase
  end

  logic       op_supported;
  logic       funct3_bad;
  logic [1:0] alu_control;
  logic [1:0] imm_src;

  assign op_supported = (bus.op == OP_LW) || (bus.op == OP_SW) || (bus.op == OP_R) ||
                        (bus.op == OP_I)  || (bus.op == OP_JAL) || (bus.op == OP_BEQ);

  // ALU decoder. Subtraction needs both R-type (op[5]) and funct7b5, so addi
  // with imm[10] set still adds.
  always_comb begin
    alu_control = 2'b00;
    funct3_bad  = 1'b0;
    case (alu_op)
      2'b01: alu_control = 2'b01;
      2'b10: begin
        case (bus.funct3)
          3'b000:  alu_control = (bus.op[5] & bus.funct7b5) ? 2'b01 : 2'b00;
          3'b110:  alu_control = 2'b11;
          3'b111:  alu_control = 2'b10;
          default: funct3_bad  = 1'b1;
        endcase
      end
      default: alu_control = 2'b00;
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (bus.op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
    if (!state_valid) imm_src = 2'b00;
  end

  // Zero drives PCWrite combinationally within the BEQ cycle.
  assign bus.PCWrite    = pc_update | (branch & bus.Zero);
  assign bus.AdrSrc     = adr_src;
  assign bus.MemWrite   = mem_write;
  assign bus.IRWrite    = ir_write;
  assign bus.RegWrite   = reg_write;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ImmSrc     = imm_src;
  assign bus.ALUControl = alu_control;
  assign bus.IllegalOp  = ((state == DECODE) && !op_supported) ||
                          (((state == EXECUTER) || (state == EXECUTEI)) && funct3_bad);
  assign bus.State      = state;

endmodule

// File: tb/tb_riscv_mc_controller.sv
module tb_riscv_mc_controller;

  logic CLK;
  logic RST;
  riscv_mc_controller_if bus ();

  riscv_mc_controller dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge and settle 1 ns after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
    bus.op       = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    bus.Zero     = z;
    #1;
  endtask

  // Walks the expected state queue. The head must be the current state, and
  // each remaining entry is checked after the next edge.
  task automatic walk(input string tag);
    check({tag, "_s0"}, bus.State, exp_q.pop_front());
    while (exp_q.size() > 0) begin
      step();
      check({tag, "_seq"}, bus.State, exp_q.pop_front());
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    RST = 1'b1;
    drive(7'b0000000, 3'b000, 1'b0, 1'b0);
    #12;
    // Reset values
    check("rst_state",   bus.State, 4'd0);
    check("rst_irwrite", bus.IRWrite, 1'b1);
    check("rst_pcwrite", bus.PCWrite, 1'b1);
    check("rst_srcb",    bus.ALUSrcB, 2'b10);
    check("rst_ressrc",  bus.ResultSrc, 2'b10);
    check("rst_memw",    bus.MemWrite, 1'b0);
    check("rst_regw",    bus.RegWrite, 1'b0);
    check("rst_adrsrc",  bus.AdrSrc, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    drive(7'b0000011, 3'b010, 1'b0, 1'b1);  // lw, with Zero high to catch leaks
    step();

    // lw: states 0,1,2,3,4,0
    check("lw_decode",   bus.State, 4'd1);
    check("lw_dec_srca", bus.ALUSrcA, 2'b01);
    check("lw_dec_srcb", bus.ALUSrcB, 2'b01);
    check("lw_dec_pcw",  bus.PCWrite, 1'b0);
    check("lw_dec_ill",  bus.IllegalOp, 1'b0);
    check("lw_imm",      bus.ImmSrc, 2'b00);
    step();
    check("lw_memadr",   bus.State, 4'd2);
    check("lw_alucon",   bus.ALUControl, 2'b00);
    check("lw_adr_srca", bus.ALUSrcA, 2'b10);
    step();
    check("lw_memread",  bus.State, 4'd3);
    check("lw_rd_adr",   bus.AdrSrc, 1'b1);
    check("lw_rd_regw",  bus.RegWrite, 1'b0);
    step();
    check("lw_memwb",    bus.State, 4'd4);
    check("lw_wb_regw",  bus.RegWrite, 1'b1);
    check("lw_wb_res",   bus.ResultSrc, 2'b01);
    check("lw_wb_imm",   bus.ImmSrc, 2'b00);
    step();
    check("lw_fetch",    bus.State, 4'd0);

    // R-type sub
    drive(7'b0110011, 3'b000, 1'b1, 1'b0);
    step(); step();
    check("sub_state",   bus.State, 4'd6);
    check("sub_alucon",  bus.ALUControl, 2'b01);
    check("sub_ill",     bus.IllegalOp, 1'b0);
    step();
    check("sub_aluwb",   bus.State, 4'd7);
    check("sub_regw",    bus.RegWrite, 1'b1);
    step();
    check("sub_fetch",   bus.State, 4'd0);

    // R-type or (full CPI trace)
    drive(7'b0110011, 3'b110, 1'b0, 1'b0);
    step(); step();
    check("or_alucon",   bus.ALUControl, 2'b11);
    step(); step();
    check("or_fetch",    bus.State, 4'd0);

    // R-type and
    drive(7'b0110011, 3'b111, 1'b0, 1'b0);
    step(); step();
    check("and_alucon",  bus.ALUControl, 2'b10);
    step(); step();

    // addi with funct7b5=1 must still add
    drive(7'b0010011, 3'b000, 1'b1, 1'b0);
    exp_q = '{4'd0, 4'd1, 4'd8};
    walk("addi");
    check("addi_alucon", bus.ALUControl, 2'b00);
    check("addi_srcb",   bus.ALUSrcB, 2'b01);
    exp_q = '{4'd8, 4'd7, 4'd0};
    walk("addi_tail");

    // beq taken / not taken
    drive(7'b1100011, 3'b000, 1'b0, 1'b1);
    step(); step();
    check("beq_state",   bus.State, 4'd10);
    check("beq_alucon",  bus.ALUControl, 2'b01);
    check("beq_imm",     bus.ImmSrc, 2'b10);
    check("beq_pcw_z1",  bus.PCWrite, 1'b1);
    drive(7'b1100011, 3'b000, 1'b0, 1'b0);
    check("beq_pcw_z0",  bus.PCWrite, 1'b0);
    step();
    check("beq_fetch",   bus.State, 4'd0);

    // jal: 0,1,9,7,0
    drive(7'b1101111, 3'b000, 1'b0, 1'b0);
    step(); step();
    check("jal_state",   bus.State, 4'd9);
    check("jal_pcw",     bus.PCWrite, 1'b1);
    check("jal_srca",    bus.ALUSrcA, 2'b01);
    check("jal_srcb",    bus.ALUSrcB, 2'b10);
    check("jal_imm",     bus.ImmSrc, 2'b11);
    step();
    check("jal_aluwb",   bus.State, 4'd7);
    check("jal_regw",    bus.RegWrite, 1'b1);
    step();
    check("jal_fetch",   bus.State, 4'd0);

    // Unsupported op (ecall encoding): 2 cycles
    drive(7'b1110011, 3'b000, 1'b0, 1'b0);
    step();
    check("ill_decode",  bus.State, 4'd1);
    check("ill_pulse",   bus.IllegalOp, 1'b1);
    step();
    check("ill_fetch",   bus.State, 4'd0);
    check("ill_regw",    bus.RegWrite, 1'b0);
    check("ill_memw",    bus.MemWrite, 1'b0);
    check("ill_clear",   bus.IllegalOp, 1'b0);

    // R-type unsupported funct3 still writes back
    drive(7'b0110011, 3'b100, 1'b0, 1'b0);
    step(); step();
    check("f3_state",    bus.State, 4'd6);
    check("f3_ill",      bus.IllegalOp, 1'b1);
    check("f3_alucon",   bus.ALUControl, 2'b00);
    step();
    check("f3_aluwb",    bus.State, 4'd7);
    check("f3_regw",     bus.RegWrite, 1'b1);
    step();

    // sw: 0,1,2,5,0
    drive(7'b0100011, 3'b010, 1'b0, 1'b0);
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd5};
    walk("sw");
    check("sw_memw",     bus.MemWrite, 1'b1);
    check("sw_adrsrc",   bus.AdrSrc, 1'b1);
    check("sw_imm",      bus.ImmSrc, 2'b01);
    step();
    check("sw_fetch",    bus.State, 4'd0);

    // Reset during MEMWRITE aborts before the next edge
    step(); step(); step();
    check("rst_pre",     bus.State, 4'd5);
    #2;
    RST = 1'b1;
    #1;
    check("rst_async_st",  bus.State, 4'd0);
    check("rst_async_mw",  bus.MemWrite, 1'b0);
    step();
    check("rst_hold",    bus.State, 4'd0);
    @(negedge CLK);
    RST = 1'b0;
    step();
    check("rst_release", bus.State, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Backstop so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
